// File: rtl/handshake_buffer.sv
// Elastic FIFO stage between a valid/ready producer and consumer.
// Registered-only flow control: in_ready depends on occupancy, never on out_ready.
// A running XOR checksum accumulates every word delivered downstream.
module handshake_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    input  logic             clear,
    output logic [WIDTH-1:0] checksum
);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;
    logic             push;
    logic             pop;

    // Handshake outputs come from registered occupancy only; rst masks in_ready
    // while the buffer is held in reset.
    assign in_ready  = rst && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign checksum  = checksum_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Next-state for pointers, occupancy and checksum (clear applies before accumulate).
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        checksum_d = checksum_q;
        if (clear) begin
            checksum_d = '0;
        end
        if (pop) begin
            checksum_d = checksum_d ^ out_data;
        end
    end

    // Control state: dropped immediately on asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            checksum_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
        end
    end

    // Storage array needs no reset; contents are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_handshake_buffer.sv
// Directed testbench for handshake_buffer with a queue-based reference model
// checked on every falling clock edge, plus literal spot checks.
module tb_handshake_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      count;
    logic             clear;
    logic [WIDTH-1:0] checksum;

    int checks   = 0;
    int failures = 0;

    handshake_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .clear     (clear),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a word queue and a running checksum.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] mchk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mchk = '0;
        end else begin
            bit do_push, do_pop;
            logic [WIDTH-1:0] head;
            do_push = in_valid && (mq.size() != DEPTH);
            do_pop  = (mq.size() != 0) && out_ready;
            head    = (mq.size() != 0) ? mq[0] : '0;
            if (clear) mchk = '0;
            if (do_pop) begin
                mchk = mchk ^ head;
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back(in_data);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_data;
        exp_data = (mq.size() != 0) ? mq[0] : '0;
        check("m_in_ready",  {31'b0, in_ready},  {31'b0, (rst && mq.size() != DEPTH)});
        check("m_out_valid", {31'b0, out_valid}, {31'b0, (mq.size() != 0)});
        check("m_out_data",  out_data, exp_data);
        check("m_count",     WIDTH'(count), WIDTH'(mq.size()));
        check("m_checksum",  checksum, mchk);
    end

    // Record words the DUT will hand over on the next rising edge.
    logic [WIDTH-1:0] popped[$];
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) popped.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_list[$];
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear = 1'b0;

        // Reset and idle
        repeat (3) tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        check("rst_count", WIDTH'(count), 32'h0);
        rst = 1'b1;
        tick();
        check("idle_in_ready", {31'b0, in_ready}, 32'h1);
        check("idle_out_valid", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b1;
        repeat (2) tick();
        check("idle_oready_count", WIDTH'(count), 32'h0);
        check("idle_oready_chk", checksum, 32'h0);

        // Single word with 1-cycle latency
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        check("single_valid", {31'b0, out_valid}, 32'h1);
        check("single_data", out_data, 32'hDEADBEEF);
        tick();
        check("single_count", WIDTH'(count), 32'h0);
        check("single_chk", checksum, 32'hDEADBEEF);

        // Clear alone
        clear = 1'b1; out_ready = 1'b0;
        tick();
        clear = 1'b0;
        check("clear_alone", checksum, 32'h0);

        // Fill to full, refused push, full + pop, drain
        popped.delete();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(i);
            tick();
        end
        check("full_count", WIDTH'(count), 32'h4);
        check("full_in_ready", {31'b0, in_ready}, 32'h0);
        in_data = 32'h5;
        repeat (2) tick();
        check("refused_count", WIDTH'(count), 32'h4);
        out_ready = 1'b1;
        tick();
        check("fullpop_count", WIDTH'(count), 32'h3);
        check("fullpop_in_ready", {31'b0, in_ready}, 32'h1);
        check("fullpop_head", out_data, 32'h2);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("drain_count", WIDTH'(count), 32'h0);
        check("drain_chk", checksum, 32'h1);
        exp_list = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        check("drain_n", WIDTH'(popped.size()), 32'h5);
        for (int i = 0; i < 5 && i < popped.size(); i++) check("drain_order", popped[i], exp_list[i]);

        // Streaming with pointer wrap
        clear = 1'b1; out_ready = 1'b0;
        tick();
        clear = 1'b0;
        popped.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) check("stream_count", WIDTH'(count), 32'h1);
            in_data = WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("stream_n", WIDTH'(popped.size()), 32'd20);
        for (int i = 0; i < 20 && i < popped.size(); i++) check("stream_order", popped[i], WIDTH'(i));
        check("stream_chk", checksum, 32'h0);
        check("stream_count_end", WIDTH'(count), 32'h0);

        // Clear together with pop
        in_valid = 1'b1; in_data = 32'h12345678;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("pre_clear_chk", checksum, 32'h12345678);
        in_valid = 1'b1;
        in_data = 32'hA5A5A5A5; tick();
        in_data = 32'h7; tick();
        in_data = 32'h8; tick();
        in_data = 32'h9; clear = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        check("clearpop_chk", checksum, 32'hA5A5A5A5);
        check("clearpop_count", WIDTH'(count), 32'h3);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        check("async_count", WIDTH'(count), 32'h0);
        check("async_out_valid", {31'b0, out_valid}, 32'h0);
        check("async_in_ready", {31'b0, in_ready}, 32'h0);
        check("async_chk", checksum, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'h0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshake_buffer.md
Name: handshake_buffer

Overview:
- Elastic FIFO stage between a producer and a consumer that exchange WIDTH-bit words over handshake-style links.
- Decouples producer and consumer timing with valid/ready flow control; single clock domain.
- Keeps a running XOR checksum of every word delivered downstream, as a link-integrity check at test level.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 4, FIFO entries; power of 2, >= 2
AW, $clog2(DEPTH), derived pointer width; not overridden

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream word present
in_ready  output  1  buffer can accept a word
in_data  input  WIDTH  upstream word
out_valid  output  1  head word present
out_ready  input  1  downstream accepts head word
out_data  output  WIDTH  head word
count  output  AW+1  current occupancy, 0..DEPTH
clear  input  1  synchronous checksum clear
checksum  output  WIDTH  XOR of all words popped since reset/clear

Behaviour:
- Reset (rst=0, async assert, sync deassert by system): wr_ptr=rd_ptr=0, count=0, checksum=0, storage contents don't-care. Outputs during reset: in_ready=0, out_valid=0, out_data=0 (masked), count=0, checksum=0.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Driven from registered state only; no combinational path from out_ready.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else 0.
- No bypass: a word pushed in cycle N is visible on out_data in cycle N+1 at the earliest. Latency is 1 cycle on an empty buffer.
- Push writes mem[wr_ptr], wr_ptr+1. Pop advances rd_ptr+1. Pointers wrap modulo DEPTH (AW bits).
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count=DEPTH): in_ready=0 even when a pop occurs that cycle. The push is refused, the pop proceeds, and in_ready=1 next cycle.
- Empty (count=0): out_valid=0. A simultaneous in_valid is pushed; there is no pop.
- Simultaneous push and pop at 0<count<DEPTH: both happen and count holds.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0. Buffer holds out_data stable while out_valid=1 and out_ready=0.
- checksum on pop: checksum <= checksum ^ out_data.
- clear without pop: checksum <= 0.
- clear with pop in the same cycle: checksum <= out_data (clear first, then accumulate).
- Reset mid-operation: all state is dropped immediately; in-flight words are lost and no output glitches to valid.
- No overflow or underflow is possible by construction; no error outputs.

Test Plan:
- Reset/idle: hold rst=0, then release -> in_ready=1, out_valid=0, count=0, checksum=0. Asserting out_ready alone changes nothing.
- Single word: push 32'hDEADBEEF at cycle N with out_ready=1 -> out_valid=1, out_data=32'hDEADBEEF at N+1. Popped at N+1, so count=0 and checksum=32'hDEADBEEF at N+2.
- Fill/full: out_ready=0, push 1,2,3,4 -> count=4, in_ready=0. A fifth push with in_valid=1 is refused (word 5 stays at input). Drain gives order 1,2,3,4, then word 5 is accepted. Checksum after 1..5 popped = 1^2^3^4^5 = 32'h1.
- Full + simultaneous pop: count=4, in_valid=1 and out_ready=1 same cycle -> pop only, count=3, in_ready=1 next cycle.
- Wrap and streaming: 20 words 0..19 with in_valid and out_ready both held 1 -> one word per cycle after first, pointers wrap 5 times, output order preserved, final checksum = XOR(0..19) = 32'h0.
- Clear and reset: clear together with pop of 32'hA5A5A5A5 -> checksum=32'hA5A5A5A5. Drive rst=0 with count=3 -> count=0, out_valid=0 immediately, without waiting for a clock edge.
